// File: rtl/spi_rom_rd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_rom_rd_ctrl
//
// Sequences an SPI master engine through serial-ROM/flash READ transactions.
// A request (address, length) is turned into a framed TX FIFO stream: one
// header word, the opcode, three address bytes (MSB first), then one filler
// byte per data byte. The RX FIFO is drained in parallel. The bytes clocked
// in during the opcode/address phase are discarded, and exactly `length`
// data bytes are forwarded on a valid/ready stream.
//
// Optional feature macro: SPI_ROM_FAST_READ_EN
//   When defined, the opcode is FAST_CMD and a single dummy byte follows the
//   address. That byte is also discarded on the RX side, so the overhead is 5
//   and the longest legal request is 122 bytes.
//
// Ports:
//   clk, rst               system clock, synchronous active-low reset
//   req_valid/req_ready    request handshake; req_addr (24b), req_len (7b)
//   tx_wr, tx_data[8:0]    TX FIFO push; tx_full back-pressures the push
//   rx_rd, rx_data[7:0]    RX FIFO pop (first-word-fall-through); rx_empty
//   rd_data, rd_valid      returned ROM bytes; rd_ready from the consumer
//   done                   pulses in the cycle the last byte is accepted
//   err                    pulses the cycle after an illegal length is taken
// -----------------------------------------------------------------------------
module spi_rom_rd_ctrl #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] FAST_CMD  = 8'h0B,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [6:0]  req_len,
    output logic        tx_wr,
    output logic [8:0]  tx_data,
    input  logic        tx_full,
    output logic        rx_rd,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic        err
);

`ifdef SPI_ROM_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam int         OVH_N     = FAST_EN ? 5 : 4;
    localparam logic [6:0] OVH       = 7'(OVH_N);
    localparam logic [2:0] SKIP_INIT = 3'(OVH_N);
    localparam logic [6:0] MAX_LEN   = 7'(127 - OVH_N);
    localparam logic [7:0] OPCODE    = FAST_EN ? FAST_CMD : READ_CMD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_CMD,
        S_A2,
        S_A1,
        S_A0,
        S_DUMMY,
        S_FILL,
        S_WAITRX
    } state_t;

    state_t      state;
    logic [23:0] addr_q;
    logic [6:0]  tot_q;
    logic [6:0]  fill_cnt;
    logic [6:0]  fwd_cnt;
    logic [2:0]  skip_cnt;

    logic tx_busy;
    logic skip_pop;
    logic fwd_pop;
    logic len_bad;

    // TX/RX strobes and done are decoded from registered state, but they must
    // react to tx_full / rx_empty / rd_ready in the same cycle so the FIFOs
    // are never over- or under-run. Gating with rst makes a reset abort
    // traffic in the very cycle it is applied.
    assign tx_busy  = (state != S_IDLE) && (state != S_WAITRX);
    assign tx_wr    = rst && tx_busy && !tx_full;

    assign skip_pop = (skip_cnt != 3'd0);
    assign fwd_pop  = (skip_cnt == 3'd0) && (fwd_cnt != 7'd0) && (!rd_valid || rd_ready);
    assign rx_rd    = rst && (state != S_IDLE) && !rx_empty && (skip_pop || fwd_pop);

    assign done     = rst && (state == S_WAITRX) && (fwd_cnt == 7'd0) && rd_valid && rd_ready;

    assign len_bad  = (req_len == 7'd0) || (req_len > MAX_LEN);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        tx_data = 9'h000;
        case (state)
            S_HDR:   tx_data = {1'b1, 1'b0, tot_q};
            S_CMD:   tx_data = {1'b0, OPCODE};
            S_A2:    tx_data = {1'b0, addr_q[23:16]};
            S_A1:    tx_data = {1'b0, addr_q[15:8]};
            S_A0:    tx_data = {1'b0, addr_q[7:0]};
            S_DUMMY: tx_data = {1'b0, FILL_BYTE};
            S_FILL:  tx_data = {1'b0, FILL_BYTE};
            default: tx_data = 9'h000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            addr_q    <= 24'h000000;
            tot_q     <= 7'd0;
            fill_cnt  <= 7'd0;
            fwd_cnt   <= 7'd0;
            skip_cnt  <= 3'd0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;

            // TX sequencer: each TX state advances only on a completed push.
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready && !len_bad) begin
                        addr_q    <= req_addr;
                        tot_q     <= req_len + OVH;
                        fill_cnt  <= req_len;
                        fwd_cnt   <= req_len;
                        skip_cnt  <= SKIP_INIT;
                        req_ready <= 1'b0;
                        state     <= S_HDR;
                    end else begin
                        // An illegal length is consumed and flagged; we stay idle.
                        err       <= req_valid && req_ready && len_bad;
                        req_ready <= 1'b1;
                    end
                end
                S_HDR:   if (tx_wr) state <= S_CMD;
                S_CMD:   if (tx_wr) state <= S_A2;
                S_A2:    if (tx_wr) state <= S_A1;
                S_A1:    if (tx_wr) state <= S_A0;
                S_A0:    if (tx_wr) state <= FAST_EN ? S_DUMMY : S_FILL;
                S_DUMMY: if (tx_wr) state <= S_FILL;
                S_FILL: begin
                    if (tx_wr) begin
                        fill_cnt <= fill_cnt - 7'd1;
                        if (fill_cnt == 7'd1) state <= S_WAITRX;
                    end
                end
                S_WAITRX: begin
                    if (done) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // RX side: discard the overhead bytes, then forward data bytes.
            // A pop in the same cycle as a consumer accept reloads rd_data
            // while rd_valid stays high, giving one byte per cycle.
            if (rx_rd) begin
                if (skip_pop) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else begin
                    rd_data  <= rx_data;
                    rd_valid <= 1'b1;
                    fwd_cnt  <= fwd_cnt - 7'd1;
                end
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rom_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_rom_rd_ctrl
//
// Self-checking bench for spi_rom_rd_ctrl. The bench plays the SPI engine
// and its FIFOs. Every data word pushed to TX returns one byte into an RX
// queue. That byte is 0xFF during the opcode/address (and dummy) phase, and
// the next ROM byte of the transaction during the data phase. Expected TX
// words are built from the framing rules, and expected read data is the
// list of ROM bytes queued for the transaction.
// -----------------------------------------------------------------------------
module tb_spi_rom_rd_ctrl;

`ifdef SPI_ROM_FAST_READ_EN
    localparam int         OVH  = 5;
    localparam logic [7:0] OPC  = 8'h0B;
`else
    localparam int         OVH  = 4;
    localparam logic [7:0] OPC  = 8'h03;
`endif
    localparam int         MAX_LEN = 127 - OVH;
    localparam logic [7:0] FILL    = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'h0;
    logic [6:0]  req_len = 7'd0;
    logic        tx_wr;
    logic [8:0]  tx_data;
    logic        tx_full = 1'b0;
    logic        rx_rd;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        done;
    logic        err;

    spi_rom_rd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .rx_rd     (rx_rd),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_tx[$];
    logic [8:0] tx_log[$];
    logic [7:0] rom_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rx_q[$];

    int   rsp_idx    = 0;
    int   tx_wr_cnt  = 0;
    int   rx_rd_cnt  = 0;
    int   rdy_mode   = 0;
    int   rdy_cnt    = 0;
    int   stall_word = -1;
    int   stall_left = 0;
    bit   in_txn     = 1'b0;
    bit   done_seen  = 1'b0;
    bit   prev_hold  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then observe the
    // DUT's response and play the FIFO/engine side.
    task automatic step();
        logic [7:0] b;
        @(negedge clk);
        req_valid = 1'b0;
        tx_full   = (stall_left > 0) && (tx_log.size() == stall_word);
        if (tx_full) stall_left--;
        case (rdy_mode)
            1:       rd_ready = (rdy_cnt % 3 == 0);
            2:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = 1'b1;
        endcase
        rdy_cnt++;
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
        #1;

        if (in_txn && prev_hold) begin
            check("rd_hold_valid", 32'(rd_valid), 1);
            check("rd_hold_data", 32'(rd_data), 32'(prev_data));
        end
        prev_hold = in_txn && rd_valid && !rd_ready;
        prev_data = rd_data;

        if (rx_rd) begin
            rx_rd_cnt++;
            check("rx_rd_nonempty", 32'(rx_q.size() != 0), 1);
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end

        if (tx_full) begin
            check("tx_wr_while_full", 32'(tx_wr), 0);
            if (tx_log.size() < exp_tx.size())
                check("tx_data_while_full", 32'(tx_data), 32'(exp_tx[tx_log.size()]));
        end

        if (tx_wr) begin
            tx_wr_cnt++;
            tx_log.push_back(tx_data);
            if (tx_data[8]) begin
                rsp_idx = 0;
            end else begin
                if (rsp_idx < OVH) b = 8'hFF;
                else if (rom_q.size() != 0) b = rom_q.pop_front();
                else b = 8'hEE;
                rx_q.push_back(b);
                rsp_idx++;
            end
        end

        if (in_txn) begin
            if (rd_valid && rd_ready) begin
                check("rd_pending", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    b = exp_rd.pop_front();
                    check("rd_data", 32'(rd_data), 32'(b));
                    check("done_on_last", 32'(done), 32'(exp_rd.size() == 0));
                    if (done) done_seen = 1'b1;
                end
            end else begin
                check("done_quiet", 32'(done), 0);
            end
        end
    endtask

    // Runs one read; the caller has already filled rom_q with the ROM bytes.
    task automatic run_txn(input logic [23:0] a, input int n, input int mode,
                           input int sw, input int sc);
        exp_tx.delete();
        tx_log.delete();
        exp_rd = rom_q;
        exp_tx.push_back({1'b1, 1'b0, 7'(n + OVH)});
        exp_tx.push_back({1'b0, OPC});
        exp_tx.push_back({1'b0, a[23:16]});
        exp_tx.push_back({1'b0, a[15:8]});
        exp_tx.push_back({1'b0, a[7:0]});
        if (OVH == 5) exp_tx.push_back({1'b0, FILL});
        for (int i = 0; i < n; i++) exp_tx.push_back({1'b0, FILL});

        rdy_mode   = mode;
        rdy_cnt    = 0;
        stall_word = sw;
        stall_left = sc;
        done_seen  = 1'b0;
        prev_hold  = 1'b0;

        check("req_ready_idle", 32'(req_ready), 1);
        req_addr  = a;
        req_len   = 7'(n);
        req_valid = 1'b1;
        in_txn    = 1'b1;
        step();
        check("req_ready_drop", 32'(req_ready), 0);
        for (int c = 0; c < 3000 && !done_seen; c++) step();
        check("txn_done_seen", 32'(done_seen), 1);
        in_txn = 1'b0;
        step();
        check("req_ready_after", 32'(req_ready), 1);
        check("stall_consumed", 32'(stall_left), 0);
        check("tx_word_count", 32'(tx_log.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check("tx_word", 32'(tx_log[i]), 32'(exp_tx[i]));
        check("rd_all_delivered", 32'(exp_rd.size()), 0);
        check("rx_fifo_drained", 32'(rx_q.size()), 0);
    endtask

    initial begin
        int bad_len[3];
        int base_tx;
        int base_rx;
        int n;

        // Reset and the idle state after release.
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_tx_wr", 32'(tx_wr), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_rx_rd", 32'(rx_rd), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);

        // Directed read: 0x012345, two bytes A5 5A.
        rom_q.delete();
        rom_q.push_back(8'hA5);
        rom_q.push_back(8'h5A);
        run_txn(24'h012345, 2, 0, -1, 0);

        // Illegal lengths: err once each, no FIFO traffic, idle bytes untouched.
        bad_len[0] = 0;
        bad_len[1] = MAX_LEN + 1;
        bad_len[2] = 127;
        rx_q.push_back(8'h77);
        base_tx = tx_wr_cnt;
        base_rx = rx_rd_cnt;
        for (int i = 0; i < 3; i++) begin
            req_addr  = 24'h00ABCD;
            req_len   = 7'(bad_len[i]);
            req_valid = 1'b1;
            step();
            check("err_pulse", 32'(err), 1);
            step();
            check("err_single", 32'(err), 0);
            check("err_req_ready", 32'(req_ready), 1);
        end
        repeat (3) step();
        check("err_no_tx_wr", 32'(tx_wr_cnt), 32'(base_tx));
        check("err_no_rx_rd", 32'(rx_rd_cnt), 32'(base_rx));
        rx_q.delete();

        // TX back-pressure for 5 cycles while the A1 word is pending.
        rom_q.delete();
        for (int i = 0; i < 6; i++) rom_q.push_back(8'($urandom));
        run_txn(24'hC0FFEE, 6, 0, 3, 5);

        // Longest legal read with the consumer stalling in a 1,0,0 pattern.
        rom_q.delete();
        for (int i = 0; i < MAX_LEN; i++) rom_q.push_back(8'($urandom));
        run_txn(24'($urandom), MAX_LEN, 1, -1, 0);

        // Randomized reads.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, MAX_LEN);
            rom_q.delete();
            for (int i = 0; i < n; i++) rom_q.push_back(8'($urandom));
            run_txn(24'($urandom), n, $urandom_range(0, 2),
                    $urandom_range(0, 5), $urandom_range(0, 4));
        end

        // Reset held for 3 cycles in the middle of the fill phase.
        rom_q.delete();
        for (int i = 0; i < 20; i++) rom_q.push_back(8'($urandom));
        exp_tx.delete();
        tx_log.delete();
        exp_rd     = rom_q;
        rdy_mode   = 0;
        stall_left = 0;
        prev_hold  = 1'b0;
        req_addr   = 24'h123456;
        req_len    = 7'd20;
        req_valid  = 1'b1;
        in_txn     = 1'b1;
        step();
        for (int c = 0; c < 50 && tx_log.size() < OVH + 3; c++) step();
        check("reached_fill", 32'(tx_log.size() >= OVH + 3), 1);
        rst    = 1'b0;
        in_txn = 1'b0;
        step();
        check("abort_tx_wr", 32'(tx_wr), 0);
        check("abort_rx_rd", 32'(rx_rd), 0);
        check("abort_rd_valid", 32'(rd_valid), 0);
        check("abort_rd_data", 32'(rd_data), 0);
        check("abort_done", 32'(done), 0);
        check("abort_err", 32'(err), 0);
        step();
        step();
        rst = 1'b1;
        rx_q.delete();
        rom_q.delete();
        step();
        check("post_rst_req_ready", 32'(req_ready), 1);
        check("post_rst_tx_data", 32'(tx_data), 0);
        check("post_rst_rd_valid", 32'(rd_valid), 0);
        base_tx = tx_wr_cnt;
        repeat (10) step();
        check("post_rst_no_tx_wr", 32'(tx_wr_cnt), 32'(base_tx));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rom_rd_ctrl.md
Name: spi_rom_rd_ctrl

Overview:
Sequences the SPI master engine to perform serial-ROM/flash READ transactions. Accepts a (address, length) request and pushes a framed command stream into the engine's 9-bit TX FIFO: one header word, the opcode, 3 address bytes, then filler bytes. It drains the engine's RX FIFO, discards the bytes clocked in during opcode/address, and forwards exactly `length` data bytes on a valid/ready stream. Sits between the system-side read requester and the SPI master plus its TX/RX FIFOs.

Parameters:
READ_CMD, 8'h03, opcode for normal read
FAST_CMD, 8'h0B, opcode for fast read (used only with the optional feature)
FILL_BYTE, 8'h00, MOSI byte sent during the data phase

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  1  read request present
req_ready  out  1  controller idle, accepts request
req_addr  in  24  ROM byte address, MSB first on the wire
req_len  in  7  data bytes to read
tx_wr  out  1  TX FIFO push strobe
tx_data  out  9  TX FIFO word: [8]=header flag, [7]=rd_wr, [6:0]=count; data words have [8]=0
tx_full  in  1  TX FIFO full
rx_rd  out  1  RX FIFO pop strobe (first-word-fall-through FIFO)
rx_data  in  8  RX FIFO head
rx_empty  in  1  RX FIFO empty
rd_data  out  8  returned ROM byte
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
done  out  1  one-cycle pulse after the last byte is accepted
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. req_ready=1 from the first cycle after reset releases. tx_wr=0, tx_data=0, rx_rd=0, rd_valid=0, rd_data=0, done=0, err=0. All counters are cleared. FIFOs are not flushed; they belong to the top level. Reset asserted mid-transaction aborts it immediately.
- Overhead OVH=4: opcode plus 3 address bytes. Total byte count TOT=req_len+OVH, 7 bits.
- Legal req_len is 1..127-OVH (1..123).
  - req_len=0 or req_len>123: request is accepted (req_valid & req_ready) and err pulses the next cycle. No FIFO traffic, state stays IDLE.
- Accept: when req_valid & req_ready, latch addr/len/TOT. req_ready drops the next cycle.
- TX FSM states: IDLE -> HDR -> CMD -> A2 -> A1 -> A0 -> FILL -> WAITRX -> IDLE.
  - Each TX state emits one word. tx_wr=1 only when tx_full=0, and the state advances on that cycle. While tx_full=1, the state holds with tx_wr=0.
  - HDR word: {1'b1, 1'b0 (read, RX capture on), TOT}.
  - CMD: {1'b0, READ_CMD}. A2/A1/A0: {1'b0, addr[23:16]}, {1'b0, addr[15:8]}, {1'b0, addr[7:0]}.
  - FILL: emits {1'b0, FILL_BYTE} req_len times, down-counting a fill counter, then goes to WAITRX.
- RX side runs concurrently with the TX FSM from HDR onward, using two counters:
  - skip counter, loaded with OVH;
  - fwd counter, loaded with req_len.
- rx_rd=1 when rx_empty=0 and either skip!=0 (the byte is discarded and skip decrements) or (skip==0 and fwd!=0 and (rd_valid==0 or rd_ready==1)).
  - On a forwarding pop, rd_data<=rx_data and rd_valid<=1 on the next edge; fwd decrements.
  - rd_valid clears on rd_valid & rd_ready when no new pop occurs in that cycle.
  - Throughput is 1 byte/cycle. rd_data stays stable while rd_valid & ~rd_ready.
- WAITRX: when fwd==0 and the final rd_valid & rd_ready occurs, done pulses that cycle, and the next cycle is IDLE with req_ready=1.
- Simultaneous events:
  - A pop and a consumer accept in the same cycle load the new byte with rd_valid held at 1.
  - A TX push and an RX pop in the same cycle are independent.
- RX bytes arriving while IDLE are never popped.

Optional Feature:
SPI_ROM_FAST_READ_EN. When defined, CMD sends FAST_CMD, and a DUMMY state is inserted after A0 that emits one {1'b0, FILL_BYTE}. OVH=5, max req_len=122 (err for 123), and skip loads 5. When undefined, the behaviour is exactly as above with READ_CMD and OVH=4.

Test Plan:
- Reset held low for 3 cycles mid-FILL, then released -> all outputs 0 and req_ready=1 the cycle after release; no further tx_wr.
- addr=24'h012345, len=2, tx_full=0 -> TX words 0x106, 0x003, 0x001, 0x023, 0x045, 0x000, 0x000. An RX model returning FF,FF,FF,FF,A5,5A yields rd_data A5 then 5A, followed by a done pulse.
- len=0 and len=124 -> err pulses once each, with no tx_wr and no rx_rd.
- tx_full asserted for 5 cycles during A1 -> tx_wr=0 and tx_data unchanged while full; the word sequence is identical to an unstalled run.
- len=123 with rd_ready toggling 1,0,0,1,… -> 123 bytes are delivered in order, none lost or duplicated, rd_data stable while stalled, and rx_rd never fires with rx_empty=1.
- With SPI_ROM_FAST_READ_EN, len=1 -> header 0x106, opcode word 0x00B, one dummy word, and the 5 leading RX bytes are discarded.
